// File: rtl/case_sel_pkg.sv
// Shared types and helper functions for the pipelined range-case selector.
package case_sel_pkg;

    typedef enum logic [1:0] {
        PARALLEL = 2'd0,
        UNIQUE   = 2'd1,
        UNIQUE0  = 2'd2,
        PRIORITY = 2'd3
    } case_mode_e;

    localparam int MAX_ITEMS = 32;

    function automatic int unsigned popcount(input logic [MAX_ITEMS-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_ITEMS; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

    // Lowest set bit wins; an all-zero vector encodes to 0.
    function automatic int unsigned prio_enc(input logic [MAX_ITEMS-1:0] v);
        int unsigned idx;
        idx = 0;
        for (int i = MAX_ITEMS - 1; i >= 0; i--) begin
            if (v[i]) idx = unsigned'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/case_sel_match.sv
// Combinational range matcher: per-item [lo:hi] hit vector plus summary bits.
module case_sel_match #(
    parameter int WIDTH      = 4,
    parameter int NUM_ITEMS  = 4,
    localparam int IDX_W     = $clog2(NUM_ITEMS)
) (
    input  logic [WIDTH-1:0]           in_sel,
    input  logic [NUM_ITEMS*WIDTH-1:0] range_lo,
    input  logic [NUM_ITEMS*WIDTH-1:0] range_hi,
    output logic [NUM_ITEMS-1:0]       match,
    output logic                       multi_hit,
    output logic                       any_hit,
    output logic [IDX_W-1:0]           first_idx
);
    import case_sel_pkg::*;

    logic [MAX_ITEMS-1:0] match_ext;

    // An inverted range (lo > hi) can never satisfy both compares, so it is empty.
    always_comb begin
        match_ext = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            match_ext[i] = (range_lo[i*WIDTH +: WIDTH] <= in_sel) &&
                           (in_sel <= range_hi[i*WIDTH +: WIDTH]);
        end
        match     = match_ext[NUM_ITEMS-1:0];
        multi_hit = popcount(match_ext) > 1;
        any_hit   = |match_ext;
        first_idx = IDX_W'(prio_enc(match_ext));
    end

endmodule

// File: rtl/case_sel_engine.sv
// Two-stage range-case selector with valid/ready handshake, case-pragma
// violation flags and saturating violation counters.
module case_sel_engine #(
    parameter int WIDTH       = 4,
    parameter int NUM_ITEMS   = 4,
    parameter int OUT_W       = 5,
    parameter int CNT_W       = 8,
    parameter bit HAS_DEFAULT = 1'b1,
    localparam int IDX_W      = $clog2(NUM_ITEMS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_sel,
    input  logic [1:0]                 mode,
    input  logic [NUM_ITEMS*WIDTH-1:0] range_lo,
    input  logic [NUM_ITEMS*WIDTH-1:0] range_hi,
    input  logic [NUM_ITEMS*OUT_W-1:0] item_val,
    input  logic [OUT_W-1:0]           default_val,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_val,
    output logic [IDX_W-1:0]           out_idx,
    output logic                       out_hit,
    output logic                       viol_overlap,
    output logic                       viol_nomatch,
    output logic [CNT_W-1:0]           overlap_cnt,
    output logic [CNT_W-1:0]           nomatch_cnt,
    input  logic                       cnt_clr
);
    import case_sel_pkg::*;

    logic [NUM_ITEMS-1:0] match_c;
    logic                 multi_c, any_c;
    logic [IDX_W-1:0]     idx_c;

    case_sel_match #(
        .WIDTH     (WIDTH),
        .NUM_ITEMS (NUM_ITEMS)
    ) u_match (
        .in_sel    (in_sel),
        .range_lo  (range_lo),
        .range_hi  (range_hi),
        .match     (match_c),
        .multi_hit (multi_c),
        .any_hit   (any_c),
        .first_idx (idx_c)
    );

    logic s2_adv, s1_adv, accept;

    logic                 vld_p1_q, vld_p1_d;
    logic [NUM_ITEMS-1:0] match_p1_q, match_p1_d;
    logic                 multi_p1_q, multi_p1_d;
    logic                 any_p1_q, any_p1_d;
    logic [IDX_W-1:0]     idx_p1_q, idx_p1_d;
    case_mode_e           mode_p1_q, mode_p1_d;

    logic                 out_valid_q, out_valid_d;
    logic [OUT_W-1:0]     out_val_q, out_val_d;
    logic [IDX_W-1:0]     out_idx_q, out_idx_d;
    logic                 out_hit_q, out_hit_d;
    logic                 viol_overlap_q, viol_overlap_d;
    logic                 viol_nomatch_q, viol_nomatch_d;
    logic [CNT_W-1:0]     overlap_cnt_q, overlap_cnt_d;
    logic [CNT_W-1:0]     nomatch_cnt_q, nomatch_cnt_d;

    logic [OUT_W-1:0]     sel_val;
    logic                 ovl_c, nom_c;

    // Handshake: a full pipe still accepts when the whole chain moves this cycle.
    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = vld_p1_q && s2_adv;
    assign in_ready = rst_n && (!vld_p1_q || s2_adv);
    assign accept   = in_valid && in_ready;

    // Stage 1: capture match summary of the accepted request.
    always_comb begin
        vld_p1_d   = accept || (vld_p1_q && !s1_adv);
        match_p1_d = match_p1_q;
        multi_p1_d = multi_p1_q;
        any_p1_d   = any_p1_q;
        idx_p1_d   = idx_p1_q;
        mode_p1_d  = mode_p1_q;
        if (accept) begin
            match_p1_d = match_c;
            multi_p1_d = multi_c;
            any_p1_d   = any_c;
            idx_p1_d   = idx_c;
            mode_p1_d  = case_mode_e'(mode);
        end
    end

    // Stage 2: resolve the value, qualify violations, update counters.
    always_comb begin
        sel_val = default_val;
        for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
            if (match_p1_q[i]) sel_val = item_val[i*OUT_W +: OUT_W];
        end
        ovl_c = multi_p1_q && (mode_p1_q == UNIQUE || mode_p1_q == UNIQUE0);
        nom_c = !any_p1_q && (mode_p1_q == UNIQUE || mode_p1_q == PRIORITY) && !HAS_DEFAULT;

        out_valid_d    = out_valid_q;
        out_val_d      = out_val_q;
        out_idx_d      = out_idx_q;
        out_hit_d      = out_hit_q;
        viol_overlap_d = viol_overlap_q;
        viol_nomatch_d = viol_nomatch_q;
        if (s2_adv) begin
            out_valid_d = vld_p1_q;
            if (vld_p1_q) begin
                out_val_d      = sel_val;
                out_idx_d      = idx_p1_q;
                out_hit_d      = any_p1_q;
                viol_overlap_d = ovl_c;
                viol_nomatch_d = nom_c;
            end
        end

        overlap_cnt_d = overlap_cnt_q;
        nomatch_cnt_d = nomatch_cnt_q;
        if (cnt_clr) begin
            overlap_cnt_d = '0;
            nomatch_cnt_d = '0;
        end else if (s1_adv) begin
            if (ovl_c && overlap_cnt_q != '1) overlap_cnt_d = overlap_cnt_q + CNT_W'(1);
            if (nom_c && nomatch_cnt_q != '1) nomatch_cnt_d = nomatch_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q       <= 1'b0;
            out_valid_q    <= 1'b0;
            out_val_q      <= '0;
            out_idx_q      <= '0;
            out_hit_q      <= 1'b0;
            viol_overlap_q <= 1'b0;
            viol_nomatch_q <= 1'b0;
            overlap_cnt_q  <= '0;
            nomatch_cnt_q  <= '0;
        end else begin
            vld_p1_q       <= vld_p1_d;
            out_valid_q    <= out_valid_d;
            out_val_q      <= out_val_d;
            out_idx_q      <= out_idx_d;
            out_hit_q      <= out_hit_d;
            viol_overlap_q <= viol_overlap_d;
            viol_nomatch_q <= viol_nomatch_d;
            overlap_cnt_q  <= overlap_cnt_d;
            nomatch_cnt_q  <= nomatch_cnt_d;
        end
    end

    // Stage-1 payload is only meaningful under vld_p1_q, so it carries no reset.
    always_ff @(posedge clk) begin
        match_p1_q <= match_p1_d;
        multi_p1_q <= multi_p1_d;
        any_p1_q   <= any_p1_d;
        idx_p1_q   <= idx_p1_d;
        mode_p1_q  <= mode_p1_d;
    end

    assign out_valid    = out_valid_q;
    assign out_val      = out_val_q;
    assign out_idx      = out_idx_q;
    assign out_hit      = out_hit_q;
    assign viol_overlap = viol_overlap_q;
    assign viol_nomatch = viol_nomatch_q;
    assign overlap_cnt  = overlap_cnt_q;
    assign nomatch_cnt  = nomatch_cnt_q;

endmodule
